// File: rtl/wb_port_scheduler_if.sv
// Producer-to-scheduler result handshakes and the two register-file write ports.
// master = execution-result producers / RF observer, slave = wb_port_scheduler.
interface wb_port_scheduler_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            req0_valid, req0_ready;
  logic [XLEN-1:0] req0_pc, req0_data;
  logic [AW-1:0]   req0_addr;
  logic            req1_valid, req1_ready;
  logic [XLEN-1:0] req1_pc, req1_data;
  logic [AW-1:0]   req1_addr;
  logic            req2_valid, req2_ready;
  logic [XLEN-1:0] req2_pc, req2_data;
  logic [AW-1:0]   req2_addr;

  logic            wb1_ena, wb2_ena;
  logic [AW-1:0]   wb1_addr, wb2_addr;
  logic [XLEN-1:0] wb1_data, wb2_data, wb1_pc, wb2_pc;
  logic [1:0]      pending_cnt;

  modport master (
    output req0_valid, req0_pc, req0_addr, req0_data,
    output req1_valid, req1_pc, req1_addr, req1_data,
    output req2_valid, req2_pc, req2_addr, req2_data,
    input  req0_ready, req1_ready, req2_ready,
    input  wb1_ena, wb1_addr, wb1_data, wb1_pc,
    input  wb2_ena, wb2_addr, wb2_data, wb2_pc,
    input  pending_cnt
  );

  modport slave (
    input  req0_valid, req0_pc, req0_addr, req0_data,
    input  req1_valid, req1_pc, req1_addr, req1_data,
    input  req2_valid, req2_pc, req2_addr, req2_data,
    output req0_ready, req1_ready, req2_ready,
    output wb1_ena, wb1_addr, wb1_data, wb1_pc,
    output wb2_ena, wb2_addr, wb2_data, wb2_pc,
    output pending_cnt
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Writeback-port scheduler: one holding slot per producer, up to two round-robin
// grants per cycle onto the RF write ports, no same-cycle duplicate destinations.
module wb_port_scheduler #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  wb_port_scheduler_if.slave bus
);
  localparam int N = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } res_t;

  logic [N-1:0]       req_valid, req_ready, pend, drain;
  res_t [N-1:0]       req, slot;
  logic [1:0]         ptr, ptr_nxt, k;
  res_t [1:0]         gnt, wb_q;
  logic [1:0]         gnt_ena, wb_ena_q;

  // (p + i) mod 3 for p in 0..2, i in 0..3
  function automatic logic [1:0] wrap(input logic [1:0] p, input int i);
    logic [2:0] s;
    s = {1'b0, p} + 3'(i);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign req_valid = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
  assign req[0] = '{pc: bus.req0_pc, addr: bus.req0_addr, data: bus.req0_data};
  assign req[1] = '{pc: bus.req1_pc, addr: bus.req1_addr, data: bus.req1_data};
  assign req[2] = '{pc: bus.req2_pc, addr: bus.req2_addr, data: bus.req2_data};

  // Walk pending slots from ptr; x0 retires free, nonzero destinations take a port.
  always_comb begin
    drain   = '0;
    gnt_ena = '0;
    gnt     = '0;
    ptr_nxt = ptr;
    k       = '0;
    if (!flush) begin
      for (int i = 0; i < N; i++) begin
        k = wrap(ptr, i);
        if (pend[k]) begin
          if (slot[k].addr == '0) begin
            drain[k] = 1'b1;
            ptr_nxt  = wrap(ptr, i + 1);
          end else if (!gnt_ena[0]) begin
            gnt_ena[0] = 1'b1;
            gnt[0]     = slot[k];
            drain[k]   = 1'b1;
            ptr_nxt    = wrap(ptr, i + 1);
          end else if (!gnt_ena[1] && slot[k].addr != gnt[0].addr) begin
            gnt_ena[1] = 1'b1;
            gnt[1]     = slot[k];
            drain[k]   = 1'b1;
            ptr_nxt    = wrap(ptr, i + 1);
          end
        end
      end
    end
  end

  // A slot drained this cycle may be refilled at the same edge.
  assign req_ready = {N{~rst & ~flush}} & (~pend | drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      ptr      <= '0;
      wb_q     <= '0;
      wb_ena_q <= '0;
    end else begin
      ptr      <= ptr_nxt;
      wb_q     <= gnt;
      wb_ena_q <= gnt_ena;
      for (int j = 0; j < N; j++) begin
        if (req_valid[j] && req_ready[j]) begin
          pend[j] <= 1'b1;
          slot[j] <= req[j];
        end else if (flush || drain[j]) begin
          pend[j] <= 1'b0;
        end
      end
    end
  end

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.req2_ready  = req_ready[2];
  assign bus.wb1_ena     = wb_ena_q[0];
  assign bus.wb1_addr    = wb_q[0].addr;
  assign bus.wb1_data    = wb_q[0].data;
  assign bus.wb1_pc      = wb_q[0].pc;
  assign bus.wb2_ena     = wb_ena_q[1];
  assign bus.wb2_addr    = wb_q[1].addr;
  assign bus.wb2_data    = wb_q[1].data;
  assign bus.wb2_pc      = wb_q[1].pc;
  assign bus.pending_cnt = {1'b0, pend[0]} + {1'b0, pend[1]} + {1'b0, pend[2]};
endmodule

// File: tb/tb_wb_port_scheduler.sv
// Self-checking bench for wb_port_scheduler: directed scenarios plus random traffic
// against a queue-based reference model of the writeback rules.
module tb_wb_port_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  wb_port_scheduler_if #(.XLEN(64), .AW(5)) bus ();
  wb_port_scheduler #(.XLEN(64), .AW(5)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // producer-side stimulus
  bit          p_valid [3];
  logic [4:0]  p_addr  [3];
  logic [63:0] p_data  [3], p_pc [3];
  bit          accepted[3];
  bit          r_dut   [3];

  // reference model
  bit          m_pend [3];
  logic [4:0]  m_addr [3];
  logic [63:0] m_data [3], m_pc [3];
  int          m_ptr;
  bit          m_drain[3], m_rdy[3];
  int          g_idx[$];
  int          nptr;
  bit          e_ena [2];
  logic [4:0]  e_addr[2];
  logic [63:0] e_data[2], e_pc[2];

  function automatic void eval();
    m_drain = '{0, 0, 0};
    g_idx.delete();
    nptr = m_ptr;
    if (!rst && !flush) begin
      for (int i = 0; i < 3; i++) begin
        int s;
        s = (m_ptr + i) % 3;
        if (m_pend[s]) begin
          if (m_addr[s] == 0) begin
            m_drain[s] = 1; nptr = (s + 1) % 3;
          end else if (g_idx.size() < 2 &&
                       !(g_idx.size() == 1 && m_addr[g_idx[0]] == m_addr[s])) begin
            g_idx.push_back(s); m_drain[s] = 1; nptr = (s + 1) % 3;
          end
        end
      end
    end
    for (int j = 0; j < 3; j++) m_rdy[j] = !rst && !flush && (!m_pend[j] || m_drain[j]);
  endfunction

  function automatic void commit();
    if (rst) begin
      m_pend = '{0, 0, 0};
      m_ptr  = 0;
      for (int p = 0; p < 2; p++) begin
        e_ena[p] = 0; e_addr[p] = 0; e_data[p] = 0; e_pc[p] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (p < g_idx.size()) begin
          e_ena[p] = 1; e_addr[p] = m_addr[g_idx[p]];
          e_data[p] = m_data[g_idx[p]]; e_pc[p] = m_pc[g_idx[p]];
        end else begin
          e_ena[p] = 0; e_addr[p] = 0; e_data[p] = 0; e_pc[p] = 0;
        end
      end
      m_ptr = nptr;
      for (int j = 0; j < 3; j++) begin
        if (flush || m_drain[j]) m_pend[j] = 0;
        if (p_valid[j] && m_rdy[j]) begin
          m_pend[j] = 1; m_addr[j] = p_addr[j]; m_data[j] = p_data[j]; m_pc[j] = p_pc[j];
        end
      end
    end
  endfunction

  task automatic drive();
    bus.req0_valid = p_valid[0]; bus.req0_addr = p_addr[0]; bus.req0_data = p_data[0]; bus.req0_pc = p_pc[0];
    bus.req1_valid = p_valid[1]; bus.req1_addr = p_addr[1]; bus.req1_data = p_data[1]; bus.req1_pc = p_pc[1];
    bus.req2_valid = p_valid[2]; bus.req2_addr = p_addr[2]; bus.req2_data = p_data[2]; bus.req2_pc = p_pc[2];
  endtask

  // One clock: check ready mid-cycle, advance model at the edge, check registered outputs.
  task automatic cycle();
    int cnt;
    drive();
    #4;
    eval();
    r_dut[0] = bus.req0_ready; r_dut[1] = bus.req1_ready; r_dut[2] = bus.req2_ready;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("ready%0d", j), 64'(r_dut[j]), 64'(m_rdy[j]));
      accepted[j] = p_valid[j] && m_rdy[j];
    end
    @(posedge clk);
    commit();
    #1;
    cnt = 0;
    for (int j = 0; j < 3; j++) cnt += int'(m_pend[j]);
    chk("pending_cnt", 64'(bus.pending_cnt), 64'(cnt));
    chk("wb1_ena",  64'(bus.wb1_ena),  64'(e_ena[0]));
    chk("wb1_addr", 64'(bus.wb1_addr), 64'(e_addr[0]));
    chk("wb1_data", bus.wb1_data,      e_data[0]);
    chk("wb1_pc",   bus.wb1_pc,        e_pc[0]);
    chk("wb2_ena",  64'(bus.wb2_ena),  64'(e_ena[1]));
    chk("wb2_addr", 64'(bus.wb2_addr), 64'(e_addr[1]));
    chk("wb2_data", bus.wb2_data,      e_data[1]);
    chk("wb2_pc",   bus.wb2_pc,        e_pc[1]);
    for (int j = 0; j < 3; j++) if (accepted[j]) p_valid[j] = 0;
  endtask

  task automatic put(input int j, input logic [4:0] a, input logic [63:0] d, input logic [63:0] pc);
    p_valid[j] = 1; p_addr[j] = a; p_data[j] = d; p_pc[j] = pc;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      p_valid[j] = 0; p_addr[j] = 0; p_data[j] = 0; p_pc[j] = 0;
      m_pend[j] = 0; m_addr[j] = 0; m_data[j] = 0; m_pc[j] = 0;
    end
    m_ptr = 0;
    for (int p = 0; p < 2; p++) begin
      e_ena[p] = 0; e_addr[p] = 0; e_data[p] = 0; e_pc[p] = 0;
    end
    drive();
    @(posedge clk); #1;
    do_reset();
    chk("rst_wb1_ena", 64'(bus.wb1_ena), 64'd0);
    chk("rst_pending", 64'(bus.pending_cnt), 64'd0);

    // single result
    put(0, 5'd5, 64'hAA, 64'h8000_0000);
    cycle(); cycle();
    chk("single_wb1_ena", 64'(bus.wb1_ena), 64'd1);
    chk("single_wb1_addr", 64'(bus.wb1_addr), 64'd5);
    chk("single_wb1_data", bus.wb1_data, 64'hAA);
    chk("single_wb1_pc", bus.wb1_pc, 64'h8000_0000);
    chk("single_wb2_ena", 64'(bus.wb2_ena), 64'd0);

    // three-way contention from ptr=0
    do_reset();
    put(0, 5'd1, 64'h101, 64'h10); put(1, 5'd2, 64'h202, 64'h14); put(2, 5'd3, 64'h303, 64'h18);
    cycle(); cycle();
    chk("c3_ready2_blocked", 64'(r_dut[2]), 64'd0);
    chk("c3_wb1_addr", 64'(bus.wb1_addr), 64'd1);
    chk("c3_wb2_addr", 64'(bus.wb2_addr), 64'd2);
    cycle();
    chk("c3_ready2_free", 64'(r_dut[2]), 64'd1);
    chk("c3_wb1_addr3", 64'(bus.wb1_addr), 64'd3);
    chk("c3_wb2_ena", 64'(bus.wb2_ena), 64'd0);

    // same destination
    do_reset();
    put(0, 5'd7, 64'h11, 64'h20); put(1, 5'd7, 64'h22, 64'h24);
    cycle(); cycle();
    chk("dup_wb1_data", bus.wb1_data, 64'h11);
    chk("dup_wb2_ena", 64'(bus.wb2_ena), 64'd0);
    cycle();
    chk("dup_wb1_data2", bus.wb1_data, 64'h22);
    chk("dup_wb1_addr2", 64'(bus.wb1_addr), 64'd7);

    // x0 retire
    do_reset();
    put(0, 5'd0, 64'h33, 64'h30); put(1, 5'd4, 64'h44, 64'h34);
    cycle(); cycle();
    chk("x0_wb1_addr", 64'(bus.wb1_addr), 64'd4);
    chk("x0_wb2_ena", 64'(bus.wb2_ena), 64'd0);
    chk("x0_pending", 64'(bus.pending_cnt), 64'd0);

    // flush with all slots full
    do_reset();
    put(0, 5'd1, 64'h1, 64'h40); put(1, 5'd2, 64'h2, 64'h44); put(2, 5'd3, 64'h3, 64'h48);
    cycle();
    chk("fl_full", 64'(bus.pending_cnt), 64'd3);
    put(0, 5'd9, 64'h9, 64'h4c);
    flush = 1; cycle(); flush = 0;
    chk("fl_ready0", 64'(r_dut[0]), 64'd0);
    chk("fl_pending", 64'(bus.pending_cnt), 64'd0);
    chk("fl_wb1_ena", 64'(bus.wb1_ena), 64'd0);
    p_valid[0] = 0;
    cycle();
    chk("fl_quiet", 64'(bus.wb1_ena), 64'd0);

    // streaming with mid-stream reset
    do_reset();
    for (int c = 0; c < 20; c++) begin
      for (int j = 0; j < 3; j++)
        if (!p_valid[j]) put(j, 5'(j + 1), 64'($urandom), 64'(c * 16 + j * 4));
      rst = (c == 10);
      cycle();
      rst = 0;
      if (c == 10) begin
        chk("st_rst_wb1", 64'(bus.wb1_ena), 64'd0);
        chk("st_rst_pend", 64'(bus.pending_cnt), 64'd0);
      end else if (c >= 2 && c != 11 && c != 12) begin
        chk("st_two_writes", 64'(bus.wb1_ena & bus.wb2_ena), 64'd1);
      end
    end

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 3; j++)
        if (!p_valid[j] && $urandom_range(0, 3) != 0)
          put(j, 5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
      flush = 0; rst = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
